// File: rtl/mem_access_sequencer.sv
// rtl/mem_access_sequencer.sv - LC-3b MEM-stage data-cache access sequencer
// Turns one memory-class instruction into one or two dcache accesses and stalls until done.
module mem_access_sequencer #(
   parameter int WIDTH    = 16,
   parameter int LANES    = WIDTH / 8,
   parameter int MAX_WAIT = 255
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [3:0]       in_opcode,
   input  logic [WIDTH-1:0] in_addr,
   input  logic [WIDTH-1:0] in_sdata,
   input  logic             dmem_resp,
   input  logic [WIDTH-1:0] dmem_rdata,
   output logic             dmem_read,
   output logic             dmem_write,
   output logic [WIDTH-1:0] dmem_address,
   output logic [WIDTH-1:0] dmem_wdata,
   output logic [LANES-1:0] dmem_byte_enable,
   output logic             stall,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   output logic             out_err
);
   localparam int LB = $clog2(LANES);
   localparam int CW = $clog2(MAX_WAIT + 1);
   localparam logic [CW-1:0] WAIT_LAST = CW'(MAX_WAIT - 1);

   localparam logic [3:0] OP_LDB  = 4'b0010;
   localparam logic [3:0] OP_STB  = 4'b0011;
   localparam logic [3:0] OP_LDR  = 4'b0110;
   localparam logic [3:0] OP_STR  = 4'b0111;
   localparam logic [3:0] OP_LDI  = 4'b1010;
   localparam logic [3:0] OP_STI  = 4'b1011;
   localparam logic [3:0] OP_TRAP = 4'b1111;

   typedef enum logic [1:0] {IDLE, ACC1, ACC2, DONE} state_t;
   state_t r_state, w_next;

   logic [3:0]       r_op;
   logic [LB-1:0]    r_lane;
   logic [WIDTH-1:0] r_sdata;
   logic [CW-1:0]    r_wait;
   logic             r_rd, r_wr, r_ov, r_oe;
   logic [WIDTH-1:0] r_adr, r_wd, r_od;
   logic [LANES-1:0] r_be;

   logic             w_mem_in, w_ind_in, w_timeout, w_fin_byte, w_fin_store, w_ld_store;
   logic [3:0]       w_src_op;
   logic [WIDTH-1:0] w_src_addr, w_src_sdata, w_fin_addr, w_fin_wdata, w_load;
   logic [LANES-1:0] w_fin_be;
   logic [7:0]       w_lane_byte;

   function automatic logic f_is_mem(input logic [3:0] op);
      return op inside {OP_LDB, OP_STB, OP_LDR, OP_STR, OP_LDI, OP_STI, OP_TRAP};
   endfunction

   function automatic logic f_is_store(input logic [3:0] op);
      return op inside {OP_STB, OP_STR, OP_STI};
   endfunction

   assign w_mem_in  = in_valid && f_is_mem(in_opcode);
   assign w_ind_in  = (in_opcode == OP_LDI) || (in_opcode == OP_STI);
   assign w_timeout = ((r_state == ACC1) || (r_state == ACC2)) && !dmem_resp && (r_wait == WAIT_LAST);

   // The final access is described from the instruction in IDLE, or from the fetched pointer in ACC1.
   always_comb begin
      w_src_op    = (r_state == IDLE) ? in_opcode : r_op;
      w_src_addr  = (r_state == IDLE) ? in_addr   : dmem_rdata;
      w_src_sdata = (r_state == IDLE) ? in_sdata  : r_sdata;
      w_fin_byte  = (w_src_op == OP_LDB) || (w_src_op == OP_STB);
      w_fin_store = f_is_store(w_src_op);
      w_fin_addr  = w_fin_byte ? w_src_addr : {w_src_addr[WIDTH-1:LB], {LB{1'b0}}};
      w_fin_be    = w_fin_byte ? (LANES'(1) << w_src_addr[LB-1:0]) : {LANES{1'b1}};
      w_fin_wdata = (w_src_op == OP_STB) ? {LANES{w_src_sdata[7:0]}} : w_src_sdata;
      w_ld_store  = f_is_store(r_op);
      w_lane_byte = dmem_rdata[{r_lane, 3'b000} +: 8];
      if (w_ld_store)
         w_load = '0;
      else if (r_op == OP_LDB)
         w_load = {{(WIDTH-8){1'b0}}, w_lane_byte};
      else
         w_load = dmem_rdata;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE: if (w_mem_in) w_next = w_ind_in ? ACC1 : ACC2;
         ACC1: begin
            if (dmem_resp)      w_next = ACC2;
            else if (w_timeout) w_next = DONE;
         end
         ACC2: if (dmem_resp || w_timeout) w_next = DONE;
         DONE: w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_next;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_op    <= '0;
         r_lane  <= '0;
         r_sdata <= '0;
         r_wait  <= '0;
         r_rd    <= 1'b0;
         r_wr    <= 1'b0;
         r_adr   <= '0;
         r_wd    <= '0;
         r_be    <= '0;
         r_ov    <= 1'b0;
         r_oe    <= 1'b0;
         r_od    <= '0;
      end else begin
         r_ov <= 1'b0;
         r_oe <= 1'b0;
         case (r_state)
            IDLE: if (w_mem_in) begin
               r_op    <= in_opcode;
               r_lane  <= in_addr[LB-1:0];
               r_sdata <= in_sdata;
               r_wait  <= '0;
               if (w_ind_in) begin
                  r_rd  <= 1'b1;
                  r_wr  <= 1'b0;
                  r_adr <= {in_addr[WIDTH-1:LB], {LB{1'b0}}};
                  r_be  <= {LANES{1'b1}};
               end else begin
                  r_rd  <= !w_fin_store;
                  r_wr  <= w_fin_store;
                  r_adr <= w_fin_addr;
                  r_wd  <= w_fin_wdata;
                  r_be  <= w_fin_be;
               end
            end
            ACC1: begin
               if (dmem_resp) begin
                  r_wait <= '0;
                  r_rd   <= !w_fin_store;
                  r_wr   <= w_fin_store;
                  r_adr  <= w_fin_addr;
                  r_wd   <= w_fin_wdata;
                  r_be   <= w_fin_be;
               end else if (w_timeout) begin
                  r_rd <= 1'b0;
                  r_wr <= 1'b0;
                  r_ov <= 1'b1;
                  r_oe <= 1'b1;
                  r_od <= '0;
               end else begin
                  r_wait <= r_wait + CW'(1);
               end
            end
            ACC2: begin
               if (dmem_resp) begin
                  r_rd <= 1'b0;
                  r_wr <= 1'b0;
                  r_ov <= 1'b1;
                  r_od <= w_load;
               end else if (w_timeout) begin
                  r_rd <= 1'b0;
                  r_wr <= 1'b0;
                  r_ov <= 1'b1;
                  r_oe <= 1'b1;
                  r_od <= '0;
               end else begin
                  r_wait <= r_wait + CW'(1);
               end
            end
            default: ;
         endcase
      end
   end

   assign stall            = (r_state == ACC1) || (r_state == ACC2) || ((r_state == IDLE) && w_mem_in);
   assign dmem_read        = r_rd;
   assign dmem_write       = r_wr;
   assign dmem_address     = r_adr;
   assign dmem_wdata       = r_wd;
   assign dmem_byte_enable = r_be;
   assign out_valid        = r_ov;
   assign out_data         = r_od;
   assign out_err          = r_oe;
endmodule

// File: tb/tb_mem_access_sequencer.sv
// tb/tb_mem_access_sequencer.sv - randomized self-checking bench for mem_access_sequencer
// Inputs and checks happen on the falling edge; a transaction-level model predicts every access.
module tb_mem_access_sequencer;
   localparam int MAXW = 4;

   localparam logic [3:0] OP_LDB  = 4'b0010;
   localparam logic [3:0] OP_STB  = 4'b0011;
   localparam logic [3:0] OP_LDR  = 4'b0110;
   localparam logic [3:0] OP_STR  = 4'b0111;
   localparam logic [3:0] OP_LDI  = 4'b1010;
   localparam logic [3:0] OP_STI  = 4'b1011;
   localparam logic [3:0] OP_TRAP = 4'b1111;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic [3:0]  in_opcode;
   logic [15:0] in_addr, in_sdata;
   logic        dmem_resp;
   logic [15:0] dmem_rdata;
   logic        dmem_read, dmem_write;
   logic [15:0] dmem_address, dmem_wdata;
   logic [1:0]  dmem_byte_enable;
   logic        stall, out_valid, out_err;
   logic [15:0] out_data;

   int n_checks = 0;
   int n_fail   = 0;

   logic [3:0] mem_ops [7];
   logic [3:0] non_ops [9];

   mem_access_sequencer #(.WIDTH(16), .MAX_WAIT(MAXW)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_opcode(in_opcode), .in_addr(in_addr), .in_sdata(in_sdata),
      .dmem_resp(dmem_resp), .dmem_rdata(dmem_rdata),
      .dmem_read(dmem_read), .dmem_write(dmem_write), .dmem_address(dmem_address),
      .dmem_wdata(dmem_wdata), .dmem_byte_enable(dmem_byte_enable),
      .stall(stall), .out_valid(out_valid), .out_data(out_data), .out_err(out_err)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Runs one instruction from IDLE. A wait of MAXW or more means that access never answers.
   task automatic do_op(input logic [3:0] op, input logic [15:0] addr, input logic [15:0] sdata,
                        input int w1, input logic [15:0] rd1, input int w2, input logic [15:0] rd2);
      bit          two, aborted, fin, byteop, store, got_resp;
      int          wt;
      logic [15:0] base, e_addr, e_wd, rdv, e_out;
      logic [1:0]  e_be;
      two     = (op == OP_LDI) || (op == OP_STI);
      byteop  = (op == OP_LDB) || (op == OP_STB);
      store   = (op == OP_STB) || (op == OP_STR) || (op == OP_STI);
      aborted = 0;
      in_valid = 1'b1; in_opcode = op; in_addr = addr; in_sdata = sdata;
      #1 check_eq("accept_stall", stall, 1);
      @(negedge clk);
      for (int a = 0; a < (two ? 2 : 1) && !aborted; a++) begin
         fin = (a == 1) || !two;
         wt  = (a == 0 && two) ? w1 : w2;
         rdv = (a == 0 && two) ? rd1 : rd2;
         if (!fin) begin
            e_addr = addr & 16'hFFFE; e_be = 2'b11; e_wd = 16'h0;
         end else begin
            base   = two ? rd1 : addr;
            e_addr = byteop ? base : (base & 16'hFFFE);
            e_be   = byteop ? (2'b01 << base[0]) : 2'b11;
            e_wd   = (op == OP_STB) ? {sdata[7:0], sdata[7:0]} : sdata;
         end
         got_resp = 0;
         for (int c = 0; c < MAXW && !got_resp && !aborted; c++) begin
            in_valid  = 1'($urandom);
            in_opcode = 4'($urandom);
            check_eq("req_read",  dmem_read,  (fin && store) ? 0 : 1);
            check_eq("req_write", dmem_write, (fin && store) ? 1 : 0);
            check_eq("req_addr",  dmem_address, e_addr);
            check_eq("req_be",    dmem_byte_enable, e_be);
            if (fin && store) check_eq("req_wdata", dmem_wdata, e_wd);
            check_eq("busy_stall", stall, 1);
            check_eq("busy_valid", out_valid, 0);
            if (c == wt) begin
               dmem_resp = 1'b1; dmem_rdata = rdv;
               got_resp = 1;
            end else begin
               dmem_resp = 1'b0; dmem_rdata = 16'($urandom);
               if (c == MAXW - 1) aborted = 1;
            end
            @(negedge clk);
            dmem_resp = 1'b0;
         end
      end
      if (aborted || store) e_out = 16'h0;
      else if (op == OP_LDB) e_out = (rd2 >> (8 * addr[0])) & 16'h00FF;
      else e_out = rd2;
      check_eq("done_valid", out_valid, 1);
      check_eq("done_err",   out_err, aborted ? 1 : 0);
      check_eq("done_data",  out_data, e_out);
      in_valid = 1'b1; in_opcode = OP_LDR; in_addr = 16'h0102;
      #1;
      check_eq("done_stall", stall, 0);
      check_eq("done_rw",    {dmem_read, dmem_write}, 0);
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      check_eq("post_valid", out_valid, 0);
      check_eq("post_err",   out_err, 0);
      check_eq("post_rw",    {dmem_read, dmem_write}, 0);
   endtask

   task automatic gap_cycle();
      if ($urandom_range(0, 1) == 0) begin
         in_valid = 1'b1; in_opcode = non_ops[$urandom_range(0, 8)];
      end else begin
         in_valid = 1'b0; in_opcode = mem_ops[$urandom_range(0, 6)];
      end
      #1 check_eq("gap_stall", stall, 0);
      @(negedge clk);
      #1 check_eq("gap_rw", {dmem_read, dmem_write}, 0);
      in_valid = 1'b0;
   endtask

   initial begin
      mem_ops = '{OP_LDB, OP_STB, OP_LDR, OP_STR, OP_LDI, OP_STI, OP_TRAP};
      non_ops = '{4'b0000, 4'b0001, 4'b0100, 4'b0101, 4'b1000, 4'b1001, 4'b1100, 4'b1101, 4'b1110};
      rst_n = 1'b0; in_valid = 1'b0; in_opcode = 4'h0; in_addr = 16'h0; in_sdata = 16'h0;
      dmem_resp = 1'b0; dmem_rdata = 16'h0;
      @(negedge clk); @(negedge clk);
      check_eq("rst_rw",    {dmem_read, dmem_write}, 0);
      check_eq("rst_addr",  dmem_address, 0);
      check_eq("rst_wdata", dmem_wdata, 0);
      check_eq("rst_be",    dmem_byte_enable, 0);
      check_eq("rst_out",   {out_valid, out_err, out_data}, 0);
      check_eq("rst_stall", stall, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // reset while the second-level read is outstanding
      in_valid = 1'b1; in_opcode = OP_LDR; in_addr = 16'h1235; in_sdata = 16'h0;
      @(negedge clk);
      in_valid = 1'b0;
      check_eq("mid_read", dmem_read, 1);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_eq("mid_rst_read",  dmem_read, 0);
      check_eq("mid_rst_addr",  dmem_address, 0);
      check_eq("mid_rst_stall", stall, 0);
      check_eq("mid_rst_valid", out_valid, 0);
      @(negedge clk);
      check_eq("mid_rst_valid2", out_valid, 0);
      rst_n = 1'b1;
      @(negedge clk);
      check_eq("mid_rst_valid3", out_valid, 0);

      do_op(OP_LDR, 16'h3005, 16'h0000, 0, 16'h0, 0, 16'hBEEF);
      do_op(OP_STB, 16'h4001, 16'h12AB, 0, 16'h0, 1, 16'h0);
      do_op(OP_LDB, 16'h4001, 16'h0000, 0, 16'h0, 0, 16'h7F80);
      do_op(OP_LDB, 16'h4000, 16'h0000, 0, 16'h0, 2, 16'h7F80);
      do_op(OP_LDI, 16'h2000, 16'h0000, 0, 16'h5003, 3, 16'h1234);
      do_op(OP_STI, 16'h2001, 16'hCAFE, 1, 16'h6000, 0, 16'h0);
      do_op(OP_TRAP, 16'h0025, 16'h0000, 0, 16'h0, 0, 16'h1A2B);
      do_op(OP_LDR, 16'h3005, 16'h0000, 0, 16'h0, MAXW, 16'hBEEF);
      do_op(OP_LDR, 16'h3005, 16'h0000, 0, 16'h0, MAXW - 1, 16'hBEEF);
      do_op(OP_LDI, 16'h2000, 16'h0000, MAXW, 16'h5003, 0, 16'h1234);
      gap_cycle();

      for (int i = 0; i < 80; i++) begin
         do_op(mem_ops[$urandom_range(0, 6)], 16'($urandom), 16'($urandom),
               $urandom_range(0, MAXW + 1), 16'($urandom), $urandom_range(0, MAXW + 1), 16'($urandom));
         if ($urandom_range(0, 2) == 0) gap_cycle();
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/mem_access_sequencer.md
Name: mem_access_sequencer

Overview:
- MEM-stage sequencer for the pipelined LC-3b datapath; turns a decoded memory-class instruction into one or two data-cache accesses.
- Single access: LDR, STR, LDB, STB, TRAP vector fetch. Two accesses: LDI, STI.
- Stalls the upstream pipeline until the access sequence completes, then delivers load data and a completion pulse to writeback.
- Generalised in data width and byte lanes, with a response-timeout watchdog.

Parameters:
- WIDTH, 16, data/address word width in bits; must be a multiple of 8 and at least 16.
- LANES, WIDTH/8, byte lanes per word; derived, do not override.
- MAX_WAIT, 255, maximum cycles one access may wait for dmem_resp before abort; must be at least 1.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  MEM-stage instruction valid.
- in_opcode  in  4  LC-3b opcode: ldb 0010, stb 0011, ldr 0110, str 0111, ldi 1010, sti 1011, trap 1111.
- in_addr  in  WIDTH  effective address computed in EX.
- in_sdata  in  WIDTH  store source register value.
- dmem_resp  in  1  data cache access complete.
- dmem_rdata  in  WIDTH  data cache read data; valid when dmem_resp=1.
- dmem_read  out  1  read request.
- dmem_write  out  1  write request.
- dmem_address  out  WIDTH  access address.
- dmem_wdata  out  WIDTH  write data.
- dmem_byte_enable  out  LANES  lane write mask.
- stall  out  1  hold all upstream stages.
- out_valid  out  1  one-cycle completion pulse.
- out_data  out  WIDTH  load result (LDR, LDB, LDI, TRAP).
- out_err  out  1  completion was a timeout abort; valid with out_valid.

Behaviour:
- Memory-class opcodes: the seven listed under in_opcode. Any other opcode, or in_valid=0, is ignored: stall=0, no request.
- States: IDLE, ACC1, ACC2, DONE.
- Reset (asynchronous, effective immediately):
  - state=IDLE.
  - dmem_read=0, dmem_write=0, dmem_address=0, dmem_wdata=0, dmem_byte_enable=0.
  - out_valid=0, out_data=0, out_err=0.
  - Wait counter cleared.
  - Reset mid-access drops any pending request; there is no completion pulse.
- stall is combinational. It is 1 when:
  - state is ACC1 or ACC2, or
  - state is IDLE and in_valid=1 with a memory-class opcode.
- stall is 0 in DONE.
- IDLE, memory-class op with in_valid=1:
  - Latch opcode, in_addr, in_sdata.
  - Next state is ACC1, except single-access ops go directly to ACC2.
- Request signals are registered and asserted from the first cycle in ACC1/ACC2. They stay stable until the cycle dmem_resp=1.
- Word accesses:
  - Address low log2(LANES) bits are cleared.
  - byte_enable is all ones.
- Byte accesses (LDB/STB):
  - lane = addr[log2(LANES)-1:0]; byte_enable is one-hot at that lane.
  - STB wdata replicates sdata[7:0] into every lane.
  - LDB out_data is the selected lane of rdata, zero-extended.
- ACC1 (LDI/STI only):
  - Word read at the aligned latched address.
  - On dmem_resp: capture rdata as the pointer, then go to ACC2.
- ACC2:
  - LDR/LDB/LDI/TRAP read; STR/STB/STI write.
  - LDI/STI use the captured pointer, aligned.
  - On dmem_resp: capture load data, go to DONE.
- DONE:
  - out_valid=1 for exactly one cycle.
  - out_data holds the load result, or 0 for stores.
  - Next state IDLE. in_valid is ignored in DONE; the next instruction is sampled in IDLE.
- Latency with a zero-wait cache (resp in the first request cycle):
  - Single access: accept cycle T, request at T+1, out_valid at T+2.
  - Double access: out_valid at T+3.
- Watchdog:
  - The counter increments each request cycle without dmem_resp and resets on entry to each access.
  - If a request has been pending MAX_WAIT cycles with no resp: drop the request, go to DONE with out_err=1, out_data=0.
  - A resp arriving in the same cycle as the limit wins; there is no error.
- dmem_read and dmem_write are never both 1.
- out_err is held 0 except in an aborted DONE cycle.

Test Plan:
- Reset asserted mid-ACC2 with dmem_read=1 -> dmem_read drops immediately, state IDLE, out_valid never pulses; next LDR executes normally.
- LDR addr=0x3005, rdata=0xBEEF, zero-wait -> dmem_address=0x3004, byte_enable=11, stall high 2 cycles, out_valid at T+2, out_data=0xBEEF.
- STB addr=0x4001, sdata=0x12AB -> dmem_write=1, byte_enable=10, wdata=0xABAB, out_data=0.
- LDB addr=0x4001, rdata=0x7F80 -> byte_enable=11 is not used; read returns lane 1, out_data=0x007F.
- LDI addr=0x2000: first read returns 0x5003, second read at 0x5002 returns 0x1234 after 3 wait cycles -> out_data=0x1234. STI with pointer 0x6000 writes sdata at 0x6000 with byte_enable=11.
- LDR with dmem_resp held low, MAX_WAIT=4 -> request high 4 cycles, then DONE with out_err=1, out_data=0. Repeat with resp in cycle 4 -> out_err=0.
